readout_trigger_scheduler: RTL

//  Arbitrates chip, software and periodic trigger sources into one readout sequencer for the 40 MHz chip/AD9228 readout path.
//  Per accepted trigger: gates chip read clock for NUM_DATA cycles, drives AD9228 read enable, timestamps the event.

---
 rtl/readout_trigger_scheduler.sv | 250 +++++++++++++++++++++++++
 1 files changed

// File: rtl/readout_trigger_scheduler.sv
// Arbitrates chip, software and periodic triggers into one readout sequencer for the chip/AD9228 path.
// Latency: chip trigger -> evt_start 3 clk (2-FF sync + edge detect + registered FSM output); sw 2 clk.
// Backpressure: requests seen while busy or while downstream_ready is low are dropped and counted, never queued.
//
// Ports:
//   clk, rstn          40 MHz readout clock, async active-low reset
//   trig_from_chip     asynchronous chip trigger (synchronized internally)
//   sw_trig            software trigger level, rising edge requests an event
//   src_enable[2:0]    enables: [0] chip, [1] sw, [2] periodic
//   period             periodic interval in clk cycles (0 = periodic off)
//   holdoff            dead cycles after each readout, sampled when the readout ends
//   downstream_ready   capture sink can accept a new event
//   clear_counters     synchronous clear of accepted/dropped counters
//   read_clk_en        chip read clock gate enable, NUM_DATA cycles per event
//   adc_read_en        AD9228 sample-valid window, NUM_DATA cycles, one cycle behind read_clk_en
//   evt_start/evt_done 1-cycle pulses at event accept / end of readout window
//   evt_source         request bits present in the accepting cycle
//   evt_timestamp      free-running timestamp captured in the accepting cycle
//   busy               sequencer not idle
//   trig_accepted/trig_dropped  saturating event counters
module readout_trigger_scheduler #(
  parameter int NUM_DATA   = 1280,
  parameter int TRIG_CNT_W = 16,
  parameter int PERIOD_W   = 24,
  parameter int HOLDOFF_W  = 16,
  parameter int TS_W       = 32
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  trig_from_chip,
  input  logic                  sw_trig,
  input  logic [2:0]            src_enable,
  input  logic [PERIOD_W-1:0]   period,
  input  logic [HOLDOFF_W-1:0]  holdoff,
  input  logic                  downstream_ready,
  input  logic                  clear_counters,
  output logic                  read_clk_en,
  output logic                  adc_read_en,
  output logic                  evt_start,
  output logic                  evt_done,
  output logic [2:0]            evt_source,
  output logic [TS_W-1:0]       evt_timestamp,
  output logic                  busy,
  output logic [TRIG_CNT_W-1:0] trig_accepted,
  output logic [TRIG_CNT_W-1:0] trig_dropped
);

  localparam int RCNT_W = $clog2(NUM_DATA + 1);
  localparam logic [RCNT_W-1:0] RCNT_LAST = RCNT_W'(NUM_DATA);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_READ    = 2'd1,
    S_HOLDOFF = 2'd2
  } state_t;

  // Trigger front end
  logic chip_s1_q, chip_s1_d;
  logic chip_s2_q, chip_s2_d;
  logic chip_s3_q, chip_s3_d;
  logic sw_s1_q, sw_s1_d;
  logic sw_s2_q, sw_s2_d;
  logic [PERIOD_W-1:0] pcnt_q, pcnt_d;
  logic chip_rise, sw_rise, per_tick;
  logic [2:0] req;
  logic any_req;

  // Sequencer
  state_t                 state_q, state_d;
  logic [RCNT_W-1:0]      rcnt_q, rcnt_d;
  logic [HOLDOFF_W-1:0]   hcnt_q, hcnt_d;
  logic                   rce_q, rce_d;
  logic                   adc_q, adc_d;
  logic                   start_q, start_d;
  logic                   done_q, done_d;
  logic                   busy_q, busy_d;
  logic [2:0]             src_q, src_d;
  logic [TS_W-1:0]        evts_q, evts_d;
  logic [TS_W-1:0]        ts_q, ts_d;
  logic [TRIG_CNT_W-1:0]  acc_q, acc_d;
  logic [TRIG_CNT_W-1:0]  drop_q, drop_d;
  logic                   acc_inc, drop_inc;

  // Request generation: chip goes through a 2-FF synchronizer, the third
  // flop only provides the previous value for edge detection.
  always_comb begin
    chip_s1_d = trig_from_chip;
    chip_s2_d = chip_s1_q;
    chip_s3_d = chip_s2_q;
    sw_s1_d   = sw_trig;
    sw_s2_d   = sw_s1_q;
    chip_rise = chip_s2_q & ~chip_s3_q;
    sw_rise   = sw_s1_q & ~sw_s2_q;

    // '>=' rather than '==' so that shrinking period below the running
    // count fires on the very next cycle instead of wrapping the counter.
    per_tick = 1'b0;
    pcnt_d   = '0;
    if (src_enable[2] && (period != '0)) begin
      if (pcnt_q >= (period - PERIOD_W'(1))) begin
        per_tick = 1'b1;
      end else begin
        pcnt_d = pcnt_q + PERIOD_W'(1);
      end
    end

    req     = {per_tick, sw_rise, chip_rise} & src_enable;
    any_req = |req;
    ts_d    = ts_q + TS_W'(1);
  end

  // Readout sequencer; all outputs are computed here and registered.
  always_comb begin
    state_d  = state_q;
    rcnt_d   = rcnt_q;
    hcnt_d   = hcnt_q;
    rce_d    = 1'b0;
    adc_d    = 1'b0;
    start_d  = 1'b0;
    done_d   = 1'b0;
    src_d    = src_q;
    evts_d   = evts_q;
    acc_inc  = 1'b0;
    drop_inc = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          if (downstream_ready) begin
            start_d = 1'b1;
            src_d   = req;
            evts_d  = ts_q;
            rce_d   = 1'b1;
            rcnt_d  = RCNT_W'(1);
            acc_inc = 1'b1;
            state_d = S_READ;
          end else begin
            drop_inc = 1'b1;
          end
        end
      end

      S_READ: begin
        drop_inc = any_req;
        // adc_read_en trails read_clk_en by one cycle, so the last read
        // clock's sample is still valid in the cycle the gate closes.
        adc_d = 1'b1;
        if (rcnt_q < RCNT_LAST) begin
          rce_d  = 1'b1;
          rcnt_d = rcnt_q + RCNT_W'(1);
        end else begin
          done_d  = 1'b1;
          rcnt_d  = '0;
          hcnt_d  = holdoff;
          state_d = (holdoff == '0) ? S_IDLE : S_HOLDOFF;
        end
      end

      S_HOLDOFF: begin
        drop_inc = any_req;
        if (hcnt_q <= HOLDOFF_W'(1)) begin
          hcnt_d  = '0;
          state_d = S_IDLE;
        end else begin
          hcnt_d = hcnt_q - HOLDOFF_W'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
        rcnt_d  = '0;
        hcnt_d  = '0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // Saturating counters; a clear in the same cycle as an increment wins.
  always_comb begin
    acc_d  = acc_q;
    drop_d = drop_q;
    if (clear_counters) begin
      acc_d  = '0;
      drop_d = '0;
    end else begin
      if (acc_inc && !(&acc_q)) begin
        acc_d = acc_q + TRIG_CNT_W'(1);
      end
      if (drop_inc && !(&drop_q)) begin
        drop_d = drop_q + TRIG_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      chip_s1_q <= 1'b0;
      chip_s2_q <= 1'b0;
      chip_s3_q <= 1'b0;
      sw_s1_q   <= 1'b0;
      sw_s2_q   <= 1'b0;
      pcnt_q    <= '0;
      ts_q      <= '0;
      state_q   <= S_IDLE;
      rcnt_q    <= '0;
      hcnt_q    <= '0;
      rce_q     <= 1'b0;
      adc_q     <= 1'b0;
      start_q   <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      src_q     <= '0;
      evts_q    <= '0;
      acc_q     <= '0;
      drop_q    <= '0;
    end else begin
      chip_s1_q <= chip_s1_d;
      chip_s2_q <= chip_s2_d;
      chip_s3_q <= chip_s3_d;
      sw_s1_q   <= sw_s1_d;
      sw_s2_q   <= sw_s2_d;
      pcnt_q    <= pcnt_d;
      ts_q      <= ts_d;
      state_q   <= state_d;
      rcnt_q    <= rcnt_d;
      hcnt_q    <= hcnt_d;
      rce_q     <= rce_d;
      adc_q     <= adc_d;
      start_q   <= start_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      src_q     <= src_d;
      evts_q    <= evts_d;
      acc_q     <= acc_d;
      drop_q    <= drop_d;
    end
  end

  assign read_clk_en   = rce_q;
  assign adc_read_en   = adc_q;
  assign evt_start     = start_q;
  assign evt_done      = done_q;
  assign evt_source    = src_q;
  assign evt_timestamp = evts_q;
  assign busy          = busy_q;
  assign trig_accepted = acc_q;
  assign trig_dropped  = drop_q;

endmodule
